// File: rtl/grid_line_clear_ctrl.sv
// Line-clear sequencer for a dual-port grid RAM: scans bottom-up, removes full rows, shifts rows down.
// Optional scoring is built when LINE_CLEAR_SCORE_EN is defined; otherwise score is tied to zero.
module grid_line_clear_ctrl #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            lines_cleared,
  output logic [15:0]           score,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_data_a,
  output logic                  mem_we_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [DATA_WIDTH-1:0] mem_q_b
);
  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] COLS2_A   = AW'(2 * COLS);
  localparam logic [AW-1:0] BASE_LAST = AW'((ROWS - 1) * COLS);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SHIFT, S_CLEAR, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_row, r_drow;
  logic [AW-1:0] r_base, r_dbase, r_addr_a, r_addr_b;
  logic          r_full, r_we, r_busy, r_done;
  logic [4:0]    r_lines;
  logic          w_full, w_pass_end;

  // Running AND over the row; the word returned this cycle belongs to the previous address.
  assign w_full     = r_full & (mem_q_b != '0);
  assign w_pass_end = (r_state == S_SCAN) && (r_cnt == CW'(COLS)) && !w_full && (r_row == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_row    <= '0;
      r_drow   <= '0;
      r_base   <= '0;
      r_dbase  <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_full   <= 1'b0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_lines  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state  <= S_SCAN;
          r_busy   <= 1'b1;
          r_row    <= RW'(ROWS - 1);
          r_base   <= BASE_LAST;
          r_addr_b <= BASE_LAST;
          r_cnt    <= '0;
          r_full   <= 1'b1;
          r_lines  <= '0;
        end
        S_SCAN: begin
          if (r_cnt != '0) r_full <= w_full;
          if (r_cnt < CW'(COLS - 1)) r_addr_b <= r_addr_b + 1'b1;
          if (r_cnt != CW'(COLS)) r_cnt <= r_cnt + 1'b1;
          else begin
            r_cnt <= '0;
            if (w_full) begin
              if (r_row == '0) begin
                r_state  <= S_CLEAR;
                r_we     <= 1'b1;
                r_addr_a <= '0;
              end else begin
                r_state  <= S_SHIFT;
                r_drow   <= r_row;
                r_dbase  <= r_base;
                r_addr_b <= r_base - COLS_A;
                r_addr_a <= r_base;
              end
            end else if (r_row == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_row    <= r_row - 1'b1;
              r_base   <= r_base - COLS_A;
              r_addr_b <= r_base - COLS_A;
              r_full   <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          // Reads at cnt 0..COLS-1, writes lag by one at cnt 1..COLS.
          if (r_cnt < CW'(COLS - 1)) r_addr_b <= r_addr_b + 1'b1;
          if (r_cnt != '0 && r_cnt != CW'(COLS)) r_addr_a <= r_addr_a + 1'b1;
          if (r_cnt != CW'(COLS)) begin
            r_we  <= 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (r_drow == RW'(1)) begin
              r_state  <= S_CLEAR;
              r_we     <= 1'b1;
              r_addr_a <= '0;
            end else begin
              r_drow   <= r_drow - 1'b1;
              r_dbase  <= r_dbase - COLS_A;
              r_addr_b <= r_dbase - COLS2_A;
              r_addr_a <= r_dbase - COLS_A;
              r_we     <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (r_cnt != CW'(COLS - 1)) begin
            r_cnt    <= r_cnt + 1'b1;
            r_addr_a <= r_addr_a + 1'b1;
          end else begin
            r_cnt    <= '0;
            r_we     <= 1'b0;
            if (r_lines < 5'(ROWS)) r_lines <= r_lines + 1'b1;
            r_state  <= S_SCAN;
            r_addr_b <= r_base;
            r_full   <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign lines_cleared = r_lines;
  assign mem_we_a      = r_we;
  assign mem_addr_a    = r_addr_a;
  assign mem_addr_b    = r_addr_b;
  assign mem_data_a    = (r_state == S_SHIFT && r_we) ? mem_q_b : '0;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] r_score;
  logic [15:0] w_pts;
  logic [16:0] w_sum;

  always_comb begin
    w_pts = 16'd0;
    case (r_lines)
      5'd0:    w_pts = 16'd0;
      5'd1:    w_pts = 16'd40;
      5'd2:    w_pts = 16'd100;
      5'd3:    w_pts = 16'd300;
      default: w_pts = 16'd1200;
    endcase
  end

  assign w_sum = {1'b0, r_score} + {1'b0, w_pts};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_score <= '0;
    else if (w_pass_end) r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  assign score = r_score;
`else
  assign score = 16'h0000;
`endif
endmodule

// File: tb/tb_grid_line_clear_ctrl.sv
// Directed bench for grid_line_clear_ctrl with a behavioural dual-port grid RAM (COLS=10, ROWS=20).
module tb_grid_line_clear_ctrl;
  logic       clk = 1'b0;
  logic       reset, start;
  logic       busy, done, mem_we_a;
  logic [4:0] lines_cleared;
  logic [15:0] score;
  logic [7:0] mem_addr_a, mem_addr_b, mem_data_a, mem_q_b;

  logic [7:0] mem [0:255];
  logic [7:0] exp_mem [0:199];
  logic       tb_clr, tb_we;
  logic [7:0] tb_addr, tb_data;
  int         done_cnt = 0, we_cnt = 0;
  int         n_assert = 0, n_fail = 0;
  int         lat, d0, w0;

  always #5 clk = ~clk;

  grid_line_clear_ctrl #(.COLS(10), .ROWS(20), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .score(score),
    .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a),
    .mem_addr_b(mem_addr_b), .mem_q_b(mem_q_b)
  );

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
    mem_q_b <= mem[mem_addr_b];
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mem_we_a) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_grid();
    @(negedge clk); tb_clr = 1'b1;
    @(negedge clk); tb_clr = 1'b0;
    for (int i = 0; i < 200; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic set_cell(input int a, input logic [7:0] d);
    @(negedge clk); tb_we = 1'b1; tb_addr = 8'(a); tb_data = d;
    @(negedge clk); tb_we = 1'b0;
  endtask

  task automatic fill_row(input int r, input logic [7:0] d);
    for (int c = 0; c < 10; c++) set_cell(r * 10 + c, d);
  endtask

  function automatic int grid_diffs();
    int n = 0;
    for (int i = 0; i < 200; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Pulse start, count cycles until done (bounded); optionally re-pulse start at cycle re_at.
  task automatic run_pass(input int re_at, output int cyc);
    int c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; c = 1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && c < 3000) begin
      if (c == re_at) start = 1'b1;
      @(negedge clk); start = 1'b0; c++;
    end
    cyc = c;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; tb_clr = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_lines", {27'd0, lines_cleared}, 32'd0);
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_we", {31'd0, mem_we_a}, 32'd0);
    chk("rst_addr_a", {24'd0, mem_addr_a}, 32'd0);
    chk("rst_addr_b", {24'd0, mem_addr_b}, 32'd0);
    chk("rst_data_a", {24'd0, mem_data_a}, 32'd0);
    reset = 1'b1;

    // Empty grid
    clear_grid();
    d0 = done_cnt; w0 = we_cnt;
    run_pass(0, lat);
    chk("empty_latency", lat, 221);
    chk("empty_lines", {27'd0, lines_cleared}, 32'd0);
    chk("empty_no_we", we_cnt - w0, 0);
    chk("empty_done_pulses", done_cnt - d0, 1);

    // One full row with a loose cell above it
    clear_grid();
    fill_row(19, 8'h01);
    set_cell(18 * 10 + 3, 8'h05);
    exp_mem[19 * 10 + 3] = 8'h05;
    w0 = we_cnt;
    run_pass(0, lat);
    chk("one_latency", lat, 451);
    chk("one_lines", {27'd0, lines_cleared}, 32'd1);
    chk("one_we_beats", we_cnt - w0, 200);
    chk("one_grid", grid_diffs(), 0);
    chk("one_score", {16'd0, score},
`ifdef LINE_CLEAR_SCORE_EN
        32'd40);
`else
        32'd0);
`endif

    // Two full rows split by a partial row
    clear_grid();
    fill_row(19, 8'h03);
    fill_row(17, 8'h07);
    set_cell(18 * 10, 8'h02);
    exp_mem[190] = 8'h02;
    w0 = we_cnt;
    run_pass(0, lat);
    chk("two_latency", lat, 670);
    chk("two_lines", {27'd0, lines_cleared}, 32'd2);
    chk("two_we_beats", we_cnt - w0, 390);
    chk("two_grid", grid_diffs(), 0);

    // Four stacked full rows, twice
    for (int p = 0; p < 2; p++) begin
      clear_grid();
      for (int r = 16; r < 20; r++) fill_row(r, 8'(r));
      run_pass(0, lat);
      chk("four_lines", {27'd0, lines_cleared}, 32'd4);
      chk("four_grid", grid_diffs(), 0);
`ifdef LINE_CLEAR_SCORE_EN
      chk("four_score", {16'd0, score}, (p == 0) ? 32'd1340 : 32'd2540);
`else
      chk("four_score", {16'd0, score}, 32'd0);
`endif
    end

    // Start pulsed mid-SCAN is ignored
    clear_grid();
    d0 = done_cnt;
    run_pass(50, lat);
    chk("restart_latency", lat, 221);
    chk("restart_lines", {27'd0, lines_cleared}, 32'd0);
    repeat (300) @(negedge clk);
    chk("restart_done_pulses", done_cnt - d0, 1);
    chk("restart_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of SHIFT
    clear_grid();
    fill_row(19, 8'hAA);
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    chk("shift_we_before_rst", {31'd0, mem_we_a}, 32'd1);
    chk("shift_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_we", {31'd0, mem_we_a}, 32'd0);
    chk("midrst_score", {16'd0, score}, 32'd0);
    chk("midrst_lines", {27'd0, lines_cleared}, 32'd0);
    @(negedge clk); reset = 1'b1;
    w0 = we_cnt;
    repeat (30) @(negedge clk);
    chk("postrst_idle", {31'd0, busy}, 32'd0);
    chk("postrst_no_we", we_cnt - w0, 0);
    chk("postrst_no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
